// File: rtl/pending_encoder_pkg.sv
// Shared sizes, scan-direction type and code-to-onehot helper for the 4-input
// pending encoder.
package pending_encoder_pkg;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic {
        ScanDown = 1'b0,
        ScanUp   = 1'b1
    } scan_dir_e;

    function automatic logic [N_IN-1:0] onehot2(input logic [CODE_W-1:0] code);
        logic [N_IN-1:0] vec;
        vec       = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational 4-way priority picker: first set bit of vec, scanning from
// start either downward or upward with mod-4 wrap.
module prio_pick4
    import pending_encoder_pkg::*;
(
    input  logic [N_IN-1:0]   vec,
    input  logic [CODE_W-1:0] start,
    input  scan_dir_e         dir,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] pos;

    always_comb begin
        idx = '0;
        pos = '0;
        any = |vec;
        // Walk the scan order backwards so the highest-priority hit is written last.
        for (int k = N_IN - 1; k >= 0; k--) begin
            pos = (dir == ScanUp) ? start + CODE_W'(k) : start - CODE_W'(k);
            if (vec[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/pending_encoder4in.sv
// Sequential 4-to-2 encoder: latches request events into a pending register and
// presents a held grant code until the consumer acknowledges it.
module pending_encoder4in
    import pending_encoder_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 0,
    parameter int unsigned EDGE_MODE   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_IN-1:0]   req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_IN-1:0]   pending,
    output logic              lost
);

    logic [N_IN-1:0]   req_q;
    logic [N_IN-1:0]   set;
    logic [N_IN-1:0]   clr;
    logic [N_IN-1:0]   pending_next;
    logic [CODE_W-1:0] rr_last;
    logic [CODE_W-1:0] rr_base;
    logic [CODE_W-1:0] pick_start;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;
    logic              accept;
    scan_dir_e         pick_dir;

    assign accept       = valid & ack;
    assign set          = (EDGE_MODE != 0) ? (req & ~req_q) : req;
    assign clr          = accept ? onehot2(code) : '0;
    assign pending_next = (pending & ~clr) | set;

    // rr_last moves on the same edge as the new pick, so scan past the code being retired.
    assign rr_base    = accept ? code : rr_last;
    assign pick_start = (ROUND_ROBIN != 0) ? rr_base + 1'b1 : CODE_W'(N_IN - 1);
    assign pick_dir   = (ROUND_ROBIN != 0) ? ScanUp : ScanDown;

    prio_pick4 u_pick (
        .vec   (pending_next),
        .start (pick_start),
        .dir   (pick_dir),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= '0;
            pending <= '0;
            lost    <= 1'b0;
            rr_last <= CODE_W'(N_IN - 1);
            code    <= '0;
            valid   <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= pending_next;
            lost    <= |(set & pending & ~clr);
            if (accept) begin
                rr_last <= code;
            end
            // Grant is frozen while presented and unacknowledged.
            if (!valid || ack) begin
                valid <= pick_any;
                code  <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_pending_encoder4in.sv
// Scoreboard bench for pending_encoder4in: a fixed-priority edge-mode instance and a
// round-robin level-mode instance share stimulus, each checked against its own model.
module tb_pending_encoder4in;

    typedef struct packed {
        logic [1:0] code;
        logic       valid;
        logic [3:0] pend;
        logic       lost;
    } obs_t;

    typedef struct {
        logic [3:0] pend;
        int         code;
        bit         valid;
        bit         lost;
        int         last;
        logic [3:0] prev;
    } mstate_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       ack;

    logic [1:0] code_fx, code_rr;
    logic       valid_fx, valid_rr;
    logic [3:0] pend_fx, pend_rr;
    logic       lost_fx, lost_rr;

    int checks   = 0;
    int failures = 0;

    obs_t    q_fx[$];
    obs_t    q_rr[$];
    mstate_t st_fx;
    mstate_t st_rr;

    always #5 clk = ~clk;

    pending_encoder4in #(.ROUND_ROBIN(0), .EDGE_MODE(1)) dut_fx (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .ack     (ack),
        .code    (code_fx),
        .valid   (valid_fx),
        .pending (pend_fx),
        .lost    (lost_fx)
    );

    pending_encoder4in #(.ROUND_ROBIN(1), .EDGE_MODE(0)) dut_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .ack     (ack),
        .code    (code_rr),
        .valid   (valid_rr),
        .pending (pend_rr),
        .lost    (lost_rr)
    );

    function automatic mstate_t mreset();
        mstate_t s;
        s.pend  = 4'b0;
        s.code  = 0;
        s.valid = 0;
        s.lost  = 0;
        s.last  = 3;
        s.prev  = 4'b0;
        return s;
    endfunction

    // One clock edge of the behavioural model: event capture, ack retirement, then grant.
    function automatic mstate_t mstep(mstate_t s, logic [3:0] r, logic a, bit rr, bit em);
        mstate_t n;
        bit taken;
        bit ev;
        bit drop;
        int idx;
        n     = s;
        taken = s.valid && (a === 1'b1);
        n.lost = 0;
        for (int i = 0; i < 4; i++) begin
            ev   = em ? (r[i] && !s.prev[i]) : r[i];
            drop = taken && (s.code == i);
            if (ev && s.pend[i] && !drop) n.lost = 1;
            n.pend[i] = ev || (s.pend[i] && !drop);
        end
        n.prev = r;
        if (taken) n.last = s.code;
        if (!s.valid || a) begin
            n.valid = 0;
            for (int k = 0; k < 4; k++) begin
                idx = rr ? (n.last + 1 + k) % 4 : 3 - k;
                if (!n.valid && n.pend[idx]) begin
                    n.valid = 1;
                    n.code  = idx;
                end
            end
        end
        return n;
    endfunction

    function automatic obs_t to_obs(mstate_t s);
        obs_t o;
        o.code  = 2'(s.code);
        o.valid = s.valid;
        o.pend  = s.pend;
        o.lost  = s.lost;
        return o;
    endfunction

    function automatic obs_t mk_obs(logic [1:0] c, logic v, logic [3:0] p, logic l);
        obs_t o;
        o.code  = c;
        o.valid = v;
        o.pend  = p;
        o.lost  = l;
        return o;
    endfunction

    // code is only meaningful while valid, unless strict (reset value checks).
    task automatic check_obs(input string name, input obs_t got, input obs_t exp, input bit strict);
        bit bad;
        checks++;
        bad = (got.valid !== exp.valid) || (got.pend !== exp.pend) || (got.lost !== exp.lost)
              || ((exp.valid || strict) && (got.code !== exp.code));
        if (bad) begin
            failures++;
            $display("FAIL %s t=%0t: got code=%0d valid=%b pending=%b lost=%b, want code=%0d valid=%b pending=%b lost=%b",
                     name, $time, got.code, got.valid, got.pend, got.lost,
                     exp.code, exp.valid, exp.pend, exp.lost);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (q_fx.size() > 0) begin
            e = q_fx.pop_front();
            check_obs("fixed_edge", mk_obs(code_fx, valid_fx, pend_fx, lost_fx), e, 1'b0);
        end
        if (q_rr.size() > 0) begin
            e = q_rr.pop_front();
            check_obs("rr_level", mk_obs(code_rr, valid_rr, pend_rr, lost_rr), e, 1'b0);
        end
    end

    task automatic tick(input logic [3:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        st_fx = mstep(st_fx, r, a, 1'b0, 1'b1);
        st_rr = mstep(st_rr, r, a, 1'b1, 1'b0);
        q_fx.push_back(to_obs(st_fx));
        q_rr.push_back(to_obs(st_rr));
        #1;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick(4'($urandom & $urandom), 1'($urandom));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        ack     = 1'b0;
        st_fx   = mreset();
        st_rr   = mreset();
        #12;
        check_obs("reset_fixed", mk_obs(code_fx, valid_fx, pend_fx, lost_fx), '0, 1'b1);
        check_obs("reset_rr", mk_obs(code_rr, valid_rr, pend_rr, lost_rr), '0, 1'b1);
        req     = 4'b0000;
        reset_n = 1'b1;

        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        // one-shot 0101 then drain with acks
        tick(4'b0101, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        // held grant is not preempted by a higher line
        tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b1000, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        // double event on an already-pending line
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        // ack coincident with a new event on the granted line
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0100, 1'b1);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        // all lines requesting, ack every cycle
        tick(4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) tick(4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) tick(4'b0000, 1'b1);

        random_cycles(1500);

        // asynchronous reset in the middle of a grant
        tick(4'b0110, 1'b0);
        tick(4'b0000, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_obs("async_reset_fixed", mk_obs(code_fx, valid_fx, pend_fx, lost_fx), '0, 1'b1);
        check_obs("async_reset_rr", mk_obs(code_rr, valid_rr, pend_rr, lost_rr), '0, 1'b1);
        q_fx.delete();
        q_rr.delete();
        st_fx = mreset();
        st_rr = mreset();
        req   = 4'b1111;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        // req held across release counts as a fresh edge
        tick(4'b1111, 1'b0);
        tick(4'b1111, 1'b1);
        random_cycles(1500);

        @(negedge clk);
        #1;
        checks++;
        if (q_fx.size() != 0 || q_rr.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0",
                     q_fx.size(), q_rr.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
